// File: rtl/exc_collect_pkg.sv
// exc_collect_pkg: shared definitions for the exception collection stage.
// Holds exception vector bit positions, memory access size codes, the
// flush/redirect state encoding and the default exception entry address.
package exc_collect_pkg;

  // Exception vector layout: {PC_AdEL, RI, OV, SYSCALL, BREAK, AdEL, AdES}
  localparam int VEC_W       = 7;
  localparam int VEC_PC_ADEL = 6;
  localparam int VEC_RI      = 5;
  localparam int VEC_OV      = 4;
  localparam int VEC_SYSCALL = 3;
  localparam int VEC_BREAK   = 2;
  localparam int VEC_ADEL    = 1;
  localparam int VEC_ADES    = 0;

  // Default redirect target for exceptions and interrupts
  localparam logic [31:0] EXC_ENTRY_DEF = 32'hbfc00380;

  // Memory access size encodings
  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } mem_size_e;

  // Flush / redirect sequencing
  typedef enum logic [1:0] {
    ST_NORMAL   = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_REDIRECT = 2'd2
  } exc_state_e;

  // Per-instruction flags carried from ID into EXE
  typedef struct packed {
    logic bd;
    logic pc_adel;
    logic ri;
    logic syscall;
    logic brk;
    logic eret;
  } inst_flags_t;

endpackage

// File: rtl/exc_collect_align_chk.sv
// exc_align_chk: flags a misaligned data access from size and low address bits.
// Latency: purely combinational.
// Backpressure: none; evaluated every cycle.
// Ports:
//   size       in  2  access size (byte / half / word)
//   addr_lo    in  2  low two bits of the effective address
//   misaligned out 1  access crosses its natural alignment
module exc_align_chk
  import exc_collect_pkg::*;
(
  input  logic [1:0] size,
  input  logic [1:0] addr_lo,
  output logic       misaligned
);

  always_comb begin
    misaligned = 1'b0;
    case (size)
      SIZE_HALF: misaligned = addr_lo[0];
      SIZE_WORD: misaligned = (addr_lo != 2'b00);
      default:   misaligned = 1'b0;
    endcase
  end

endmodule

// File: rtl/exc_collect.sv
// exc_collect: collects per-instruction exception flags across ID/EXE and sequences flush + redirect.
// Latency: exception vector combinational from EXE; flush 1 cycle after accept, redirect the cycle after.
// Backpressure: redirect_valid/redirect_pc held until redirect_ack; pipeline transfers ignored meanwhile.
//
// Ports:
//   clk, rst                           clock, synchronous active-high reset
//   fs_to_ds_valid, ds_allowin, fs_pc  IF->ID transfer and fetched PC
//   ds_to_es_valid, es_allowin         ID->EXE transfer
//   ds_bd, ds_ri, ds_syscall,
//   ds_break, ds_eret                  decode results for the ID instruction
//   es_ov, es_mem_re, es_mem_we,
//   es_mem_size, es_mem_addr           EXE overflow and memory access info
//   exe_ready_go, ex_int_handle        EXE completion, CP0 handling request
//   epc_value                          CP0 EPC, ERET return target
//   exc_vec, exc_bd, exc_badvaddr,
//   epc_out, eret_out                  exception report to CP0
//   es_mem_kill                        suppress the EXE memory access
//   exe_refresh                        one-cycle pipeline flush pulse
//   redirect_valid, redirect_pc,
//   redirect_ack                       redirect handshake with IF
// Optional build macro EXC_TRACE_EN adds exc_count (16) and last_vec (7).
module exc_collect
  import exc_collect_pkg::*;
#(
  parameter int              PC_W      = 32,
  parameter logic [PC_W-1:0] EXC_ENTRY = PC_W'(EXC_ENTRY_DEF)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fs_to_ds_valid,
  input  logic             ds_allowin,
  input  logic [PC_W-1:0]  fs_pc,
  input  logic             ds_to_es_valid,
  input  logic             es_allowin,
  input  logic             ds_bd,
  input  logic             ds_ri,
  input  logic             ds_syscall,
  input  logic             ds_break,
  input  logic             ds_eret,
  input  logic             es_ov,
  input  logic             es_mem_re,
  input  logic             es_mem_we,
  input  logic [1:0]       es_mem_size,
  input  logic [PC_W-1:0]  es_mem_addr,
  input  logic             exe_ready_go,
  input  logic             ex_int_handle,
  input  logic [PC_W-1:0]  epc_value,
  output logic [VEC_W-1:0] exc_vec,
  output logic             exc_bd,
  output logic [PC_W-1:0]  exc_badvaddr,
  output logic [PC_W-1:0]  epc_out,
  output logic             eret_out,
  output logic             es_mem_kill,
  output logic             exe_refresh,
  output logic             redirect_valid,
  output logic [PC_W-1:0]  redirect_pc,
  input  logic             redirect_ack
`ifdef EXC_TRACE_EN
  ,
  output logic [15:0]      exc_count,
  output logic [VEC_W-1:0] last_vec
`endif
);

  exc_state_e  state;

  // ID shadow
  logic            ds_valid;
  logic [PC_W-1:0] ds_pc;
  logic            ds_pc_adel;
  inst_flags_t     ds_flags;

  // EXE shadow
  logic            es_valid;
  logic [PC_W-1:0] es_pc;
  inst_flags_t     es_flags;

  logic            in_normal;
  logic            es_live;
  logic            fs_fire;
  logic            ds_fire;
  logic            misaligned;
  logic            earlier_exc;
  logic [VEC_W-1:0] vec;
  logic            take_flush;

  assign in_normal = (state == ST_NORMAL);
  assign es_live   = es_valid & in_normal;
  // Transfers only count while the pipeline is not being flushed/redirected.
  assign fs_fire   = fs_to_ds_valid & ds_allowin & in_normal;
  assign ds_fire   = ds_to_es_valid & es_allowin & in_normal;

  // Decode results are only meaningful while ID holds a valid instruction.
  always_comb begin
    ds_flags = '0;
    if (ds_valid) begin
      ds_flags.bd      = ds_bd;
      ds_flags.pc_adel = ds_pc_adel;
      ds_flags.ri      = ds_ri;
      ds_flags.syscall = ds_syscall;
      ds_flags.brk     = ds_break;
      ds_flags.eret    = ds_eret;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ds_valid   <= 1'b0;
      ds_pc      <= '0;
      ds_pc_adel <= 1'b0;
      es_valid   <= 1'b0;
      es_pc      <= '0;
      es_flags   <= '0;
    end else if (!in_normal) begin
      ds_valid <= 1'b0;
      es_valid <= 1'b0;
    end else begin
      // EXE samples the old ID contents before ID is overwritten.
      if (ds_fire) begin
        es_valid <= 1'b1;
        es_pc    <= ds_pc;
        es_flags <= ds_flags;
      end
      if (fs_fire) begin
        ds_valid   <= 1'b1;
        ds_pc      <= fs_pc;
        ds_pc_adel <= (fs_pc[1:0] != 2'b00);
      end
    end
  end

  exc_align_chk u_align_chk (
    .size       (es_mem_size),
    .addr_lo    (es_mem_addr[1:0]),
    .misaligned (misaligned)
  );

  // A fetch fault hides decode faults; any earlier-stage fault hides EXE faults.
  assign earlier_exc = es_flags.pc_adel | es_flags.ri | es_flags.syscall | es_flags.brk;

  always_comb begin
    vec = '0;
    if (es_live) begin
      vec[VEC_PC_ADEL] = es_flags.pc_adel;
      vec[VEC_RI]      = es_flags.ri      & ~es_flags.pc_adel;
      vec[VEC_SYSCALL] = es_flags.syscall & ~es_flags.pc_adel;
      vec[VEC_BREAK]   = es_flags.brk     & ~es_flags.pc_adel;
      vec[VEC_OV]      = es_ov                   & ~earlier_exc;
      vec[VEC_ADEL]    = es_mem_re & misaligned & ~earlier_exc;
      vec[VEC_ADES]    = es_mem_we & misaligned & ~earlier_exc;
    end
  end

  assign exc_vec      = vec;
  assign es_mem_kill  = |vec;
  assign exc_bd       = es_live & es_flags.bd;
  assign exc_badvaddr = !es_live ? '0 : (es_flags.pc_adel ? es_pc : es_mem_addr);
  assign epc_out      = !es_live ? '0 : (es_flags.bd ? es_pc - PC_W'(4) : es_pc);
  // Any exception on the same instruction overrides ERET.
  assign eret_out     = es_live & es_flags.eret & ~(|vec);

  assign take_flush   = es_live & exe_ready_go & (ex_int_handle | eret_out);

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_NORMAL;
      exe_refresh    <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
`ifdef EXC_TRACE_EN
      exc_count      <= 16'd0;
      last_vec       <= '0;
`endif
    end else begin
      case (state)
        ST_NORMAL: begin
          if (take_flush) begin
            state       <= ST_FLUSH;
            exe_refresh <= 1'b1;
            // CP0 handling takes priority over an ERET target.
            redirect_pc <= ex_int_handle ? EXC_ENTRY : epc_value;
`ifdef EXC_TRACE_EN
            if (ex_int_handle) begin
              exc_count <= exc_count + 16'd1;
              last_vec  <= vec;
            end
`endif
          end
        end
        ST_FLUSH: begin
          exe_refresh    <= 1'b0;
          redirect_valid <= 1'b1;
          state          <= ST_REDIRECT;
        end
        ST_REDIRECT: begin
          if (redirect_ack) begin
            redirect_valid <= 1'b0;
            state          <= ST_NORMAL;
          end
        end
        default: begin
          exe_refresh    <= 1'b0;
          redirect_valid <= 1'b0;
          state          <= ST_NORMAL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exc_collect.sv
// tb_exc_collect: directed bench for exc_collect with a behavioural reference
// model compared on every falling edge, plus literal expectations per scenario.
module tb_exc_collect;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fs_to_ds_valid = 0, ds_allowin = 0;
  logic [31:0] fs_pc = '0;
  logic        ds_to_es_valid = 0, es_allowin = 0;
  logic        ds_bd = 0, ds_ri = 0, ds_syscall = 0, ds_break = 0, ds_eret = 0;
  logic        es_ov = 0, es_mem_re = 0, es_mem_we = 0;
  logic [1:0]  es_mem_size = '0;
  logic [31:0] es_mem_addr = '0;
  logic        exe_ready_go = 0, ex_int_handle = 0;
  logic [31:0] epc_value = '0;
  logic        redirect_ack = 0;
  logic [6:0]  exc_vec;
  logic        exc_bd, eret_out, es_mem_kill, exe_refresh, redirect_valid;
  logic [31:0] exc_badvaddr, epc_out, redirect_pc;
`ifdef EXC_TRACE_EN
  logic [15:0] exc_count;
  logic [6:0]  last_vec;
`endif

  always #5 clk = ~clk;

  exc_collect dut (
    .clk(clk), .rst(rst),
    .fs_to_ds_valid(fs_to_ds_valid), .ds_allowin(ds_allowin), .fs_pc(fs_pc),
    .ds_to_es_valid(ds_to_es_valid), .es_allowin(es_allowin),
    .ds_bd(ds_bd), .ds_ri(ds_ri), .ds_syscall(ds_syscall), .ds_break(ds_break), .ds_eret(ds_eret),
    .es_ov(es_ov), .es_mem_re(es_mem_re), .es_mem_we(es_mem_we),
    .es_mem_size(es_mem_size), .es_mem_addr(es_mem_addr),
    .exe_ready_go(exe_ready_go), .ex_int_handle(ex_int_handle), .epc_value(epc_value),
    .exc_vec(exc_vec), .exc_bd(exc_bd), .exc_badvaddr(exc_badvaddr), .epc_out(epc_out),
    .eret_out(eret_out), .es_mem_kill(es_mem_kill), .exe_refresh(exe_refresh),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .redirect_ack(redirect_ack)
`ifdef EXC_TRACE_EN
    , .exc_count(exc_count), .last_vec(last_vec)
`endif
  );

  int n_vec = 0;
  int n_mis = 0;
  bit started = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Instruction records in ID / EXE plus a phase: 0 running, 1 flushing, 2 awaiting ack.
  bit          m_ds_valid = 0;
  logic [31:0] m_ds_pc = '0;
  bit          m_es_valid = 0;
  logic [31:0] m_es_pc = '0;
  bit          m_bd = 0, m_ri = 0, m_sys = 0, m_brk = 0, m_eret = 0;
  int          m_phase = 0;
  logic [31:0] m_target = '0;
  bit          m_refresh = 0, m_rv = 0;
  logic [15:0] m_count = '0;
  logic [6:0]  m_last = '0;

  function automatic bit m_live();
    return m_es_valid && (m_phase == 0);
  endfunction

  // Priority: fetch fault alone, else decode faults, else execute faults.
  function automatic logic [6:0] m_vec();
    int unsigned nbytes;
    bit mis;
    if (!m_live()) return 7'd0;
    if ((m_es_pc % 4) != 0) return 7'b1000000;
    if (m_ri || m_sys || m_brk) return {1'b0, m_ri, 1'b0, m_sys, m_brk, 2'b00};
    nbytes = 1 << es_mem_size;
    mis = (es_mem_addr % nbytes) != 0;
    return {2'b00, es_ov, 2'b00, es_mem_re & mis, es_mem_we & mis};
  endfunction

  function automatic bit m_eret_out();
    return m_live() && m_eret && (m_vec() == 7'd0);
  endfunction

  always @(posedge clk) begin
    bit fire;
    logic [6:0] v;
    if (rst) begin
      m_ds_valid = 0; m_ds_pc = '0; m_es_valid = 0; m_es_pc = '0;
      m_bd = 0; m_ri = 0; m_sys = 0; m_brk = 0; m_eret = 0;
      m_phase = 0; m_target = '0; m_refresh = 0; m_rv = 0; m_count = '0; m_last = '0;
    end else if (m_phase == 0) begin
      fire = m_es_valid && exe_ready_go && (ex_int_handle || m_eret_out());
      v = m_vec();
      if (ds_to_es_valid && es_allowin) begin
        m_es_valid = 1; m_es_pc = m_ds_pc;
        m_bd = m_ds_valid & ds_bd; m_ri = m_ds_valid & ds_ri; m_sys = m_ds_valid & ds_syscall;
        m_brk = m_ds_valid & ds_break; m_eret = m_ds_valid & ds_eret;
      end
      if (fs_to_ds_valid && ds_allowin) begin
        m_ds_valid = 1; m_ds_pc = fs_pc;
      end
      if (fire) begin
        m_phase = 1; m_refresh = 1;
        m_target = ex_int_handle ? 32'hbfc00380 : epc_value;
        if (ex_int_handle) begin
          m_count = m_count + 1; m_last = v;
        end
      end
    end else if (m_phase == 1) begin
      m_refresh = 0; m_rv = 1; m_phase = 2; m_ds_valid = 0; m_es_valid = 0;
    end else begin
      m_ds_valid = 0; m_es_valid = 0;
      if (redirect_ack) begin
        m_rv = 0; m_phase = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("m_exc_vec", 32'(exc_vec), 32'(m_vec()));
      chk("m_mem_kill", 32'(es_mem_kill), 32'(m_vec() != 0));
      chk("m_exc_bd", 32'(exc_bd), 32'(m_live() && m_bd));
      chk("m_badvaddr", exc_badvaddr,
          !m_live() ? 32'd0 : ((m_es_pc % 4) != 0 ? m_es_pc : es_mem_addr));
      chk("m_epc", epc_out, !m_live() ? 32'd0 : (m_bd ? m_es_pc - 32'd4 : m_es_pc));
      chk("m_eret", 32'(eret_out), 32'(m_eret_out()));
      chk("m_refresh", 32'(exe_refresh), 32'(m_refresh));
      chk("m_redir_vld", 32'(redirect_valid), 32'(m_rv));
      chk("m_redir_pc", redirect_pc, m_target);
`ifdef EXC_TRACE_EN
      chk("m_exc_count", 32'(exc_count), 32'(m_count));
      chk("m_last_vec", 32'(last_vec), 32'(m_last));
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic fetch(input logic [31:0] pc);
    fs_to_ds_valid = 1; ds_allowin = 1; fs_pc = pc;
    tick();
    fs_to_ds_valid = 0; ds_allowin = 0;
  endtask

  task automatic issue(input bit bd, input bit ri, input bit sys, input bit brk, input bit er);
    ds_to_es_valid = 1; es_allowin = 1;
    ds_bd = bd; ds_ri = ri; ds_syscall = sys; ds_break = brk; ds_eret = er;
    tick();
    ds_to_es_valid = 0; es_allowin = 0;
    ds_bd = 0; ds_ri = 0; ds_syscall = 0; ds_break = 0; ds_eret = 0;
  endtask

  task automatic take_int();
    exe_ready_go = 1; ex_int_handle = 1;
    tick();
    exe_ready_go = 0; ex_int_handle = 0;
  endtask

  task automatic finish_redirect(input int waits);
    tick();
    repeat (waits) tick();
    redirect_ack = 1;
    tick();
    redirect_ack = 0;
  endtask

  initial begin
    rst = 1;
    tick();
    started = 1;
    tick();
    rst = 0;
    @(negedge clk);
    chk("rst_vec", 32'(exc_vec), 32'd0);
    chk("rst_redir_vld", 32'(redirect_valid), 32'd0);
    chk("rst_refresh", 32'(exe_refresh), 32'd0);
    #1;

    // Fetch address fault reaches EXE, then interrupt flush
    fetch(32'hbfc00102);
    issue(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("pc_adel_vec", 32'(exc_vec), 32'h40);
    chk("pc_adel_badvaddr", exc_badvaddr, 32'hbfc00102);
    #1;
    take_int();
    @(negedge clk);
    chk("flush_pulse", 32'(exe_refresh), 32'd1);
    chk("flush_target", redirect_pc, 32'hbfc00380);
    #1;
    tick();
    @(negedge clk);
    chk("flush_pulse_end", 32'(exe_refresh), 32'd0);
    chk("redir_vld_on", 32'(redirect_valid), 32'd1);
    #1;
    redirect_ack = 1;
    tick();
    redirect_ack = 0;
    @(negedge clk);
    chk("redir_vld_off", 32'(redirect_valid), 32'd0);
    #1;

    // Delay-slot memory accesses: byte ok, half store odd, word load misaligned
    fetch(32'hbfc00204);
    issue(1, 0, 0, 0, 0);
    es_mem_re = 1; es_mem_size = 2'd0; es_mem_addr = 32'h80000003;
    @(negedge clk);
    chk("byte_ok_vec", 32'(exc_vec), 32'd0);
    #1;
    es_mem_re = 0; es_mem_we = 1; es_mem_size = 2'd1; es_mem_addr = 32'h80000001;
    @(negedge clk);
    chk("half_ades_vec", 32'(exc_vec), 32'h01);
    #1;
    es_mem_we = 0; es_mem_re = 1; es_mem_size = 2'd2; es_mem_addr = 32'h80000006;
    @(negedge clk);
    chk("word_adel_vec", 32'(exc_vec), 32'h02);
    chk("word_adel_kill", 32'(es_mem_kill), 32'd1);
    chk("word_adel_bd", 32'(exc_bd), 32'd1);
    chk("word_adel_epc", epc_out, 32'hbfc00200);
    chk("word_adel_badvaddr", exc_badvaddr, 32'h80000006);
    #1;
    take_int();
    es_mem_re = 0; es_mem_size = 2'd0; es_mem_addr = '0;
    finish_redirect(0);

    // Reserved instruction masks overflow
    fetch(32'hbfc00300);
    issue(0, 1, 0, 0, 0);
    es_ov = 1;
    @(negedge clk);
    chk("ri_masks_ov", 32'(exc_vec), 32'h20);
    #1;
    take_int();
    es_ov = 0;
    finish_redirect(1);

    // ERET with redirect held across three un-acked cycles
    epc_value = 32'hbfc00010;
    fetch(32'hbfc00400);
    issue(0, 0, 0, 0, 1);
    @(negedge clk);
    chk("eret_out", 32'(eret_out), 32'd1);
    chk("eret_vec", 32'(exc_vec), 32'd0);
    #1;
    exe_ready_go = 1;
    tick();
    exe_ready_go = 0;
    @(negedge clk);
    chk("eret_flush", 32'(exe_refresh), 32'd1);
    #1;
    tick();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("eret_hold_pc", redirect_pc, 32'hbfc00010);
      chk("eret_hold_vld", 32'(redirect_valid), 32'd1);
      #1;
      tick();
    end
    redirect_ack = 1;
    tick();
    redirect_ack = 0;
    @(negedge clk);
    chk("eret_ack_vld", 32'(redirect_valid), 32'd0);
`ifdef EXC_TRACE_EN
    chk("trace_count", 32'(exc_count), 32'd3);
    chk("trace_last", 32'(last_vec), 32'h20);
`endif
    #1;

    // Fetch fault together with ERET: exception wins
    fetch(32'hbfc00501);
    issue(0, 0, 0, 0, 1);
    @(negedge clk);
    chk("eret_vs_exc_vec", 32'(exc_vec), 32'h40);
    chk("eret_vs_exc_eret", 32'(eret_out), 32'd0);
    #1;

    // Syscall masks a misaligned store
    fetch(32'hbfc00800);
    issue(0, 0, 1, 0, 0);
    es_mem_we = 1; es_mem_size = 2'd2; es_mem_addr = 32'h80000002;
    @(negedge clk);
    chk("sys_masks_ades", 32'(exc_vec), 32'h08);
    #1;
    es_mem_we = 0; es_mem_size = 2'd0; es_mem_addr = '0;

    // Plain interrupt, then reset during REDIRECT
    fetch(32'hbfc00600);
    issue(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("int_epc", epc_out, 32'hbfc00600);
    #1;
    take_int();
    tick();
    @(negedge clk);
    chk("int_redir_vld", 32'(redirect_valid), 32'd1);
    #1;
    rst = 1;
    tick();
    rst = 0;
    @(negedge clk);
    chk("rst_redir_clear", 32'(redirect_valid), 32'd0);
    chk("rst_vec_clear", 32'(exc_vec), 32'd0);
    chk("rst_refresh_clear", 32'(exe_refresh), 32'd0);
`ifdef EXC_TRACE_EN
    chk("rst_trace_count", 32'(exc_count), 32'd0);
`endif
    #1;
    fetch(32'hbfc00702);
    issue(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("post_rst_normal", 32'(exc_vec), 32'h40);
    #1;

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
